// File: rtl/blink_sequencer.sv
// blink_sequencer
//   Drives an LED through bursts of on/off blinks. Each on or off phase lasts
//   one tick period (BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ clk
//   cycles). A burst holds blink_count blinks. If repeat_en is high at the end
//   of a burst, the LED stays off for GAP_TICKS ticks and then the burst
//   restarts.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request a burst (ignored while busy)
//   stop         in   abort any activity; overrides start and tick
//   blink_count  in   blinks per burst, latched when start is accepted
//   repeat_en    in   sampled at the end of each burst
//   led          out  registered LED drive, high only in the ON state
//   busy         out  high whenever the sequencer is not idle
//   done         out  one-cycle pulse when a sequence ends normally
module blink_sequencer #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int TICK_FREQUENCY_IN_HZ        = 2,
  parameter int COUNT_WIDTH                 = 4,
  parameter int GAP_TICKS                   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_WIDTH-1:0] blink_count,
  input  logic                   repeat_en,
  output logic                   led,
  output logic                   busy,
  output logic                   done
);

  localparam int DIV    = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [TICK_W-1:0]      tick_cnt_q,  tick_cnt_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] latched_q,   latched_d;
  logic [GAP_W-1:0]       gap_q,       gap_d;
  logic                   led_q,       led_d;
  logic                   done_q,      done_d;
  logic                   tick;

  // The tick counter only runs outside IDLE, so a tick can never fire while
  // idle and every accepted start sees a full first phase.
  assign tick = (state_q != S_IDLE) && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = '0;
    remaining_d = remaining_q;
    latched_d   = latched_q;
    gap_d       = gap_q;
    done_d      = 1'b0;

    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    if (stop) begin
      // Abort: return to IDLE silently; the tick counter restarts from 0.
      state_d     = S_IDLE;
      tick_cnt_d  = '0;
      remaining_d = '0;
      gap_d       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (blink_count != '0) begin
              latched_d   = blink_count;
              remaining_d = blink_count;
              tick_cnt_d  = '0;
              state_d     = S_ON;
            end else begin
              // Empty burst finishes immediately.
              done_d = 1'b1;
            end
          end
        end
        S_ON: begin
          if (tick) state_d = S_OFF;
        end
        S_OFF: begin
          if (tick) begin
            if (remaining_q > COUNT_ONE) begin
              remaining_d = remaining_q - COUNT_ONE;
              state_d     = S_ON;
            end else if (repeat_en) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              gap_d       = '0;
              remaining_d = latched_q;
              state_d     = S_ON;
            end else begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    led_d = (state_d == S_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      remaining_q <= '0;
      latched_q   <= '0;
      gap_q       <= '0;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      remaining_q <= remaining_d;
      latched_q   <= latched_d;
      gap_q       <= gap_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with DIV=4, GAP_TICKS=2.
module tb_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] blink_count;
  logic       repeat_en;
  logic       led;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  blink_sequencer #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(8),
    .TICK_FREQUENCY_IN_HZ       (2),
    .COUNT_WIDTH                (4),
    .GAP_TICKS                  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .blink_count(blink_count),
    .repeat_en  (repeat_en),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic l, input logic b, input logic d);
    chk({tag, ".led"},  {31'd0, led},  {31'd0, l});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; blink_count = 4'd0; repeat_en = 1'b0;
    step(); step();
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); step();
    chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0);

    // Three blinks, no repeat; a second start during ON with another count is ignored.
    start = 1'b1; blink_count = 4'd3; repeat_en = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk_out($sformatf("burst3_k%0d", k), ((k % 8) < 4), 1'b1, 1'b0);
      if (k == 2) begin start = 1'b1; blink_count = 4'd7; end
      else if (k == 3) start = 1'b0;
      step();
    end
    chk_out("burst3_done", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("burst3_after", 1'b0, 1'b0, 1'b0);

    // Two blinks with repeat, repeat cleared during the second burst.
    start = 1'b1; blink_count = 4'd2; repeat_en = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic el;
      if (k < 16)      el = ((k % 8) < 4);
      else if (k < 24) el = 1'b0;
      else             el = (((k - 24) % 8) < 4);
      chk_out($sformatf("repeat_k%0d", k), el, 1'b1, 1'b0);
      if (k == 26) repeat_en = 1'b0;
      step();
    end
    chk_out("repeat_done", 1'b0, 1'b0, 1'b1);
    step();

    // Stop during the sixth cycle of a burst.
    start = 1'b1; blink_count = 4'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_out($sformatf("stop_pre_k%0d", k), (k < 4), 1'b1, 1'b0);
      if (k == 5) stop = 1'b1;
      else step();
    end
    step();
    stop = 1'b0;
    chk_out("stop_now", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("stop_no_done", 1'b0, 1'b0, 1'b0);

    // Fresh single-blink burst after stop has a full 4-cycle ON phase.
    start = 1'b1; blink_count = 4'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_out($sformatf("restart_k%0d", k), (k < 4), 1'b1, 1'b0);
      step();
    end
    chk_out("restart_done", 1'b0, 1'b0, 1'b1);
    step();

    // Zero-count start.
    start = 1'b1; blink_count = 4'd0;
    step();
    start = 1'b0;
    chk_out("zero_done", 1'b0, 1'b0, 1'b1);
    step();
    chk_out("zero_after", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an OFF phase.
    start = 1'b1; blink_count = 4'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk_out("pre_rst_off", 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 1'b0);
    step();
    #2 rst = 1'b0;
    step(); step(); step(); step(); step();
    chk_out("idle_after_rst", 1'b0, 1'b0, 1'b0);

    // Start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; blink_count = 4'd2;
    step();
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop_idle", 1'b0, 1'b0, 1'b0);
    step();
    chk_out("start_stop_idle2", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, meaning the clk frequency.
REQ-002 SHALL have parameter TICK_FREQUENCY_IN_HZ, default 2, meaning the phase-tick rate; each LED on/off phase lasts one tick period.
REQ-003 SHALL have parameter COUNT_WIDTH, default 4, meaning the width of blink_count.
REQ-004 SHALL have parameter GAP_TICKS, default 4 (minimum 1), meaning the number of ticks of LED-off pause between repeated bursts.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request a burst; sampled on each clk edge.
REQ-008 stop  input  1  abort any activity; sampled on each clk edge.
REQ-009 blink_count  input  COUNT_WIDTH  number of blinks per burst; latched when start is accepted.
REQ-010 repeat_en  input  1  level input; sampled at the end of each burst.
REQ-011 led  output  1  registered blink output.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a sequence finishes normally.

Function
REQ-014 SHALL derive DIV = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_FREQUENCY_IN_HZ; the tick counter counts 0..DIV-1 and asserts the internal tick for one cycle when the count equals DIV-1, then wraps to 0.
REQ-015 SHALL hold the tick counter at 0 in IDLE and clear it to 0 when a start is accepted, so the first phase is exactly DIV cycles long.
REQ-016 SHALL implement states IDLE, ON, OFF and GAP; led = 1 only in ON.
REQ-017 IDLE: start=1, stop=0 and blink_count!=0 -> latch blink_count into remaining, enter ON, and assert led on the following edge (latency 1 cycle).
REQ-018 IDLE: start=1 and blink_count==0 -> stay in IDLE, keep led=0, and pulse done for one cycle.
REQ-019 ON: tick -> enter OFF.
REQ-020 OFF: tick with remaining>1 -> decrement remaining and enter ON.
REQ-021 OFF: tick with remaining==1 and repeat_en=1 -> enter GAP and clear the gap counter.
REQ-022 OFF: tick with remaining==1 and repeat_en=0 -> enter IDLE and pulse done in the same cycle busy falls.
REQ-023 GAP: count ticks; on the GAP_TICKS-th tick, reload remaining from the latched count and enter ON.
REQ-024 stop=1 in any state SHALL force IDLE on the next edge, with led=0 and busy=0, and SHALL NOT pulse done; stop has priority over start and over tick in the same cycle.
REQ-025 start while busy SHALL be ignored; the latched count SHALL NOT change mid-sequence.
REQ-026 blink_count and repeat_en changes SHALL have no effect except at the points named in REQ-017 and REQ-021/022.
REQ-027 Remaining and gap counters SHALL never wrap; remaining is never decremented below 1.

Reset
REQ-028 While rst=1: state=IDLE, led=0, busy=0, done=0, and tick, remaining and gap counters = 0; takes effect immediately, including mid-sequence.
REQ-029 After rst deasserts, no activity SHALL occur until a start is accepted.

Verification (BOARD_CLOCK_FREQUENCY_IN_HZ=8, TICK_FREQUENCY_IN_HZ=2, DIV=4, GAP_TICKS=2)
REQ-030 start pulse with blink_count=3, repeat_en=0 -> led high 4 cycles and low 4 cycles, three times, with the first rise 1 cycle after start; done pulses once at cycle 24; busy high for 24 cycles.
REQ-031 blink_count=2, repeat_en=1 -> two blinks, then led low for 4+8 cycles (OFF plus GAP), then two more blinks; clearing repeat_en during the second burst -> done pulses at the end of that burst.
REQ-032 stop asserted in cycle 6 of a burst -> led=0 and busy=0 next cycle, no done pulse; the next start begins a full new burst with a 4-cycle first ON phase.
REQ-033 start with blink_count=0 -> done pulses 1 cycle later, busy stays 0, led stays 0.
REQ-034 start pulse during ON with a different blink_count -> ignored; the original count completes.
REQ-035 rst asserted mid-OFF phase -> all outputs 0 immediately (asynchronous); start and stop asserted together in IDLE -> stays IDLE.
